// File: rtl/drac_pkg.sv
// ---------------------------------------------------------------------------
// drac_pkg
// Shared types and constants for the fetch-side queue.
//   addr_t              : 40-bit virtual address
//   fetch_queue_entry_t : one decoded-bound fetch record {pc, instr, xcpt}
//   FETCH_QUEUE_DEPTH   : default number of fetch queue entries
// ---------------------------------------------------------------------------
package drac_pkg;

    localparam int ADDR_W            = 40;
    localparam int INSTR_W           = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
        logic   xcpt;
    } fetch_queue_entry_t;

endpackage : drac_pkg

// File: rtl/fetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// fetch_queue_fifo
// Entry storage for the instruction fetch queue. Circular buffer with
// log2(DEPTH)-bit pointers and a log2(DEPTH)+1-bit occupancy count.
//   clk_i, rstn_i : clock, async active-low reset
//   clear_i       : synchronous empty (flush); wins over push/pop
//   push_i/data_i : write an entry; ignored when full unless popping too
//   pop_i         : retire the head entry (ignored when empty)
//   data_o        : head entry, zero when empty
//   full_o/empty_o/count_o : occupancy status
// ---------------------------------------------------------------------------
module fetch_queue_fifo
    import drac_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  fetch_queue_entry_t data_i,
    input  logic               pop_i,
    output fetch_queue_entry_t data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_queue_entry_t mem [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [PW-1:0]      wptr, rptr;
    logic [CW-1:0]      count;
    logic               do_push, do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == DEPTH_C);
    assign count_o = count;

    // A full queue only accepts a write when the head leaves in the same
    // cycle; otherwise the write is dropped and the contents stay intact.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else if (clear_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            // Clear before set: on a full push+pop the two pointers alias.
            if (do_pop) begin
                rptr      <= rptr + PW'(1);
                vld[rptr] <= 1'b0;
            end
            if (do_push) begin
                wptr      <= wptr + PW'(1);
                vld[wptr] <= 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload needs no reset: it is masked by the valid bit on the read side.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem[wptr] <= data_i;
        end
    end

    assign data_o = vld[rptr] ? mem[rptr] : '0;

endmodule : fetch_queue_fifo

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Decouples the icache response path from decode. Tracks the single
// outstanding icache request, captures its response into a FIFO and
// presents the head entry to decode with a valid/ready handshake.
// A flush empties the queue and, if a request is still in flight, arms
// drop_next so that its late response is discarded.
//   clk_i, rstn_i        : clock, async active-low reset
//   flush_i              : redirect/exception; kills queued + in-flight
//   req_issued_i/req_pc_i: icache accepted a request this cycle
//   resp_valid_i/resp_instr_i/resp_page_fault_i : icache response
//   fetch_ready_o        : fetch may issue a new request
//   dec_valid_o/dec_ready_i, dec_pc_o/dec_instr_o/dec_xcpt_o : to decode
//   empty_o/full_o       : queue status
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import drac_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         flush_i,
    input  logic         req_issued_i,
    input  addr_t        req_pc_i,
    input  logic         resp_valid_i,
    input  instr_t       resp_instr_i,
    input  logic         resp_page_fault_i,
    output logic         fetch_ready_o,
    output logic         dec_valid_o,
    input  logic         dec_ready_i,
    output addr_t        dec_pc_o,
    output instr_t       dec_instr_o,
    output logic         dec_xcpt_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic               pending;
    addr_t              pending_pc;
    logic               drop_next;

    logic               push, pop;
    fetch_queue_entry_t wr_entry, head;
    logic [CW-1:0]      count;
    logic [CW:0]        reserved;

    // A response is only kept if it answers the live request.
    assign push = resp_valid_i && pending && !drop_next && !flush_i;
    assign pop  = dec_valid_o && dec_ready_i && !flush_i;

    assign wr_entry.pc    = pending_pc;
    assign wr_entry.instr = resp_instr_i;
    assign wr_entry.xcpt  = resp_page_fault_i;

    fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear_i (flush_i),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full_o),
        .empty_o (empty_o),
        .count_o (count)
    );

    assign dec_valid_o = !empty_o;
    assign dec_pc_o    = head.pc;
    assign dec_instr_o = head.instr;
    assign dec_xcpt_o  = head.xcpt;

    // Slots already promised: queued entries plus the in-flight response.
    assign reserved = {1'b0, count} + {{CW{1'b0}}, pending};

    assign fetch_ready_o = (reserved < DEPTH_C)
                        && !(pending && !resp_valid_i)
                        && !drop_next;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending    <= 1'b0;
            pending_pc <= '0;
            drop_next  <= 1'b0;
        end else if (flush_i) begin
            // A request issued in the flush cycle is already on the new path.
            pending <= req_issued_i;
            if (req_issued_i) begin
                pending_pc <= req_pc_i;
            end
            // Any response still owed to the old path must be swallowed.
            drop_next <= (drop_next || pending) && !resp_valid_i;
        end else begin
            if (resp_valid_i && drop_next) begin
                drop_next <= 1'b0;
            end
            if (req_issued_i) begin
                pending    <= 1'b1;
                pending_pc <= req_pc_i;
            end else if (resp_valid_i && pending && !drop_next) begin
                pending <= 1'b0;
            end
        end
    end

endmodule : instr_fetch_queue

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
    import drac_pkg::*;

    logic   clk_i = 1'b0;
    logic   rstn_i;
    logic   flush_i, req_issued_i, resp_valid_i, resp_page_fault_i, dec_ready_i;
    addr_t  req_pc_i;
    instr_t resp_instr_i;
    logic   fetch_ready_o, dec_valid_o, dec_xcpt_o, empty_o, full_o;
    addr_t  dec_pc_o;
    instr_t dec_instr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    instr_fetch_queue #(.DEPTH(4)) dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .flush_i           (flush_i),
        .req_issued_i      (req_issued_i),
        .req_pc_i          (req_pc_i),
        .resp_valid_i      (resp_valid_i),
        .resp_instr_i      (resp_instr_i),
        .resp_page_fault_i (resp_page_fault_i),
        .fetch_ready_o     (fetch_ready_o),
        .dec_valid_o       (dec_valid_o),
        .dec_ready_i       (dec_ready_i),
        .dec_pc_o          (dec_pc_o),
        .dec_instr_o       (dec_instr_o),
        .dec_xcpt_o        (dec_xcpt_o),
        .empty_o           (empty_o),
        .full_o            (full_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; req_issued_i = 0; req_pc_i = '0;
        resp_valid_i = 0; resp_instr_i = '0; resp_page_fault_i = 0;
    endtask

    // Stimulus only: one request, its response one cycle later.
    task automatic issue_resp(input addr_t pc, input instr_t ins, input logic pf);
        req_issued_i = 1; req_pc_i = pc;
        step();
        req_issued_i = 0;
        resp_valid_i = 1; resp_instr_i = ins; resp_page_fault_i = pf;
        step();
        resp_valid_i = 0; resp_instr_i = '0; resp_page_fault_i = 0;
    endtask

    task automatic test_reset();
        n_cmp++; if (dec_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid got %b want 0", dec_valid_o); end
        n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full_o); end
        n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_fetch_ready got %b want 1", fetch_ready_o); end
        n_cmp++; if ({dec_pc_o, dec_instr_o, dec_xcpt_o} !== 73'd0) begin n_err++; $display("FAIL reset_dec_fields got %h/%h/%b want 0", dec_pc_o, dec_instr_o, dec_xcpt_o); end
    endtask

    task automatic test_basic();
        req_issued_i = 1; req_pc_i = 40'h100;
        step();
        req_issued_i = 0;
        n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready_pending got %b want 0", fetch_ready_o); end
        resp_valid_i = 1; resp_instr_i = 32'h0000_0013;
        #1;
        n_cmp++; if (dec_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_no_bypass got %b want 0", dec_valid_o); end
        step();
        idle();
        n_cmp++; if (dec_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_dec_valid got %b want 1", dec_valid_o); end
        n_cmp++; if (dec_pc_o !== 40'h100) begin n_err++; $display("FAIL basic_dec_pc got %h want 100", dec_pc_o); end
        n_cmp++; if (dec_instr_o !== 32'h0000_0013) begin n_err++; $display("FAIL basic_dec_instr got %h want 00000013", dec_instr_o); end
        dec_ready_i = 1;
        step();
        dec_ready_i = 0;
        n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL basic_pop_empty got %b want 1", empty_o); end
    endtask

    task automatic test_full();
        dec_ready_i = 0;
        for (int i = 0; i < 4; i++) issue_resp(40'h1000 + 40'(i*4), 32'hC000_0000 + 32'(i), 1'b0);
        n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", full_o); end
        n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL full_fetch_ready got %b want 0", fetch_ready_o); end
        n_cmp++; if (dec_pc_o !== 40'h1000) begin n_err++; $display("FAIL full_head_pc got %h want 1000", dec_pc_o); end
        // Out-of-contract request+response while full: response must be dropped.
        req_issued_i = 1; req_pc_i = 40'h2000;
        step();
        req_issued_i = 0;
        n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready_pending got %b want 0", fetch_ready_o); end
        resp_valid_i = 1; resp_instr_i = 32'h0000_0BAD;
        step();
        idle();
        n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL overflow_full got %b want 1", full_o); end
        n_cmp++; if (dec_pc_o !== 40'h1000 || dec_instr_o !== 32'hC000_0000) begin n_err++; $display("FAIL full_stable got %h/%h want 1000/c0000000", dec_pc_o, dec_instr_o); end
        dec_ready_i = 1;
        step();
        dec_ready_i = 0;
        n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL pop_fetch_ready got %b want 1", fetch_ready_o); end
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL pop_full got %b want 0", full_o); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (dec_pc_o !== 40'h1000 + 40'(i*4) || dec_instr_o !== 32'hC000_0000 + 32'(i)) begin n_err++; $display("FAIL drain_%0d got %h/%h want %h", i, dec_pc_o, dec_instr_o, 40'h1000 + 40'(i*4)); end
            dec_ready_i = 1;
            step();
            dec_ready_i = 0;
        end
        n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL overflow_dropped_empty got %b want 1", empty_o); end
    endtask

    task automatic test_flush();
        req_issued_i = 1; req_pc_i = 40'h200;
        step();
        req_issued_i = 0;
        flush_i = 1;
        step();
        flush_i = 0;
        n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_drop_ready got %b want 0", fetch_ready_o); end
        resp_valid_i = 1; resp_instr_i = 32'hDEAD_0000;
        step();
        idle();
        n_cmp++; if (empty_o !== 1'b1 || dec_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_discard got empty=%b valid=%b want 1/0", empty_o, dec_valid_o); end
        n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready_after got %b want 1", fetch_ready_o); end
        issue_resp(40'h400, 32'h0000_0011, 1'b0);
        n_cmp++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 40'h400 || dec_instr_o !== 32'h11) begin n_err++; $display("FAIL flush_next got %b/%h/%h want 1/400/11", dec_valid_o, dec_pc_o, dec_instr_o); end
        dec_ready_i = 1;
        step();
        dec_ready_i = 0;
    endtask

    task automatic test_page_fault();
        issue_resp(40'h8000, 32'h0, 1'b1);
        n_cmp++; if (dec_xcpt_o !== 1'b1) begin n_err++; $display("FAIL pf_xcpt got %b want 1", dec_xcpt_o); end
        n_cmp++; if (dec_pc_o !== 40'h8000 || dec_instr_o !== 32'h0) begin n_err++; $display("FAIL pf_fields got %h/%h want 8000/0", dec_pc_o, dec_instr_o); end
        dec_ready_i = 1;
        step();
        dec_ready_i = 0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) issue_resp(40'h5000 + 40'(i*4), 32'h5, 1'b0);
        dec_ready_i = 1;
        step();
        rstn_i = 0;
        #1;
        n_cmp++; if (empty_o !== 1'b1 || dec_valid_o !== 1'b0) begin n_err++; $display("FAIL midreset got empty=%b valid=%b want 1/0", empty_o, dec_valid_o); end
        dec_ready_i = 0;
        step();
        rstn_i = 1;
        step();
        resp_valid_i = 1; resp_instr_i = 32'h0000_0777;
        step();
        idle();
        n_cmp++; if (empty_o !== 1'b1 || fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL stray_resp got empty=%b ready=%b want 1/1", empty_o, fetch_ready_o); end
    endtask

    task automatic test_back_to_back();
        int exp_idx = 0;
        int ready_bad = 0;
        dec_ready_i = 1;
        for (int i = 0; i <= 10; i++) begin
            req_issued_i = (i < 10);
            req_pc_i     = 40'h3000 + 40'(i*4);
            resp_valid_i = (i > 0);
            resp_instr_i = 32'hA000_0000 + 32'(i-1);
            #1;
            if (i < 10 && fetch_ready_o !== 1'b1) ready_bad++;
            if (dec_valid_o) begin
                n_cmp++; if (dec_pc_o !== 40'h3000 + 40'(exp_idx*4) || dec_instr_o !== 32'hA000_0000 + 32'(exp_idx)) begin n_err++; $display("FAIL b2b_entry_%0d got %h/%h want %h", exp_idx, dec_pc_o, dec_instr_o, 40'h3000 + 40'(exp_idx*4)); end
                exp_idx++;
            end
            step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            if (dec_valid_o) begin
                n_cmp++; if (dec_pc_o !== 40'h3000 + 40'(exp_idx*4)) begin n_err++; $display("FAIL b2b_tail_%0d got %h want %h", exp_idx, dec_pc_o, 40'h3000 + 40'(exp_idx*4)); end
                exp_idx++;
            end
            step();
        end
        dec_ready_i = 0;
        n_cmp++; if (exp_idx !== 10) begin n_err++; $display("FAIL b2b_count got %0d want 10", exp_idx); end
        n_cmp++; if (ready_bad !== 0) begin n_err++; $display("FAIL b2b_fetch_ready got %0d stalls want 0", ready_bad); end
        n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b want 1", empty_o); end
    endtask

    initial begin
        rstn_i = 0;
        dec_ready_i = 0;
        idle();
        step();
        step();
        test_reset();
        rstn_i = 1;
        step();
        test_basic();
        test_full();
        test_flush();
        test_page_fault();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_fetch_queue
